// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } arb_owner_t;

    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Everything captured from the winning requester at grant time.
    typedef struct packed {
        arb_owner_t  owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between data and fetch requesters: data-first with an aging override.
// Latency: purely combinational.
// Backpressure: none; the caller only consults the result while idle.
//
// Ports:
//   d_req_m, i_req_m : requests with the just-completed owner already masked
//   starve_cnt       : consecutive data grants made while fetch was waiting
//   grant_vld        : some requester wins this cycle
//   grant_owner      : which one (OWN_D / OWN_I)
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             d_req_m,
    input  logic             i_req_m,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_vld,
    output arb_owner_t       grant_owner
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // A limit of zero disables the override, leaving strict data priority.
    logic force_i;
    assign force_i = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

    always_comb begin
        grant_vld   = 1'b0;
        grant_owner = OWN_D;
        if (i_req_m && (!d_req_m || force_i)) begin
            grant_vld   = 1'b1;
            grant_owner = OWN_I;
        end else if (d_req_m) begin
            grant_vld   = 1'b1;
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the CPU data port and the instruction fetch path.
// Latency: 3 cycles request-to-done with miss low; +1 per cycle of miss in WAIT.
// Backpressure: one access in flight; requesters hold level requests until their done pulse.
//
// Ports:
//   clk, rst                                  : clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done : data requester
//   i_req/i_addr -> i_rdata/i_done            : fetch requester (read only)
//   addr/wdata/write_enable/read_enable       : downstream command, enables pulse one cycle
//   rdata/miss                                : downstream response, miss=1 means not complete
//   busy/owner                                : status, owner valid while busy
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4  // 0..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        write_enable,
    output logic        read_enable,
    input  logic        miss,
    output logic        busy,
    output logic        owner
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    req_t             req_q;
    req_t             grant_req;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_vld;
    arb_owner_t       grant_owner;
    logic             d_req_m;
    logic             i_req_m;

    // The requester that completes this cycle still has its old request
    // up; hide it so the same access is not issued twice.
    assign d_req_m = d_req & ~d_done;
    assign i_req_m = i_req & ~i_done;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .d_req_m     (d_req_m),
        .i_req_m     (i_req_m),
        .starve_cnt  (starve_cnt),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    // Fields of the winner; fetch is always a read with zero write data.
    always_comb begin
        grant_req       = '0;
        grant_req.owner = grant_owner;
        if (grant_owner == OWN_I) begin
            grant_req.addr = i_addr;
        end else begin
            grant_req.we    = d_we;
            grant_req.addr  = d_addr;
            grant_req.wdata = d_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (!miss) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            req_q        <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            d_done       <= 1'b0;
            i_done       <= 1'b0;
            d_rdata      <= '0;
            i_rdata      <= '0;
        end else begin
            state        <= state_nxt;
            // Enables and done are single-cycle pulses.
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            d_done       <= 1'b0;
            i_done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        req_q        <= grant_req;
                        // Registered so the strobe lands exactly in the ISSUE cycle.
                        read_enable  <= ~grant_req.we;
                        write_enable <= grant_req.we;
                        if (grant_owner == OWN_I) begin
                            starve_cnt <= '0;
                        end else if (i_req) begin
                            if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (!miss) begin
                        if (req_q.owner == OWN_I) begin
                            i_done  <= 1'b1;
                            i_rdata <= rdata;
                        end else begin
                            d_done <= 1'b1;
                            if (!req_q.we) d_rdata <= rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr  = req_q.addr;
    assign wdata = req_q.wdata;
    assign busy  = (state != IDLE);
    assign owner = (req_q.owner == OWN_I);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we, i_req, miss;
    logic [31:0] d_addr, d_wdata, i_addr, rdata;
    logic [31:0] d_rdata, i_rdata, addr, wdata;
    logic        d_done, i_done, write_enable, read_enable, busy, owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_done       (i_done),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .miss         (miss),
        .busy         (busy),
        .owner        (owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One single-requester transaction with its hand-computed outcome.
    typedef struct {
        logic        is_i;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          miss_n;
        int          exp_done;
        logic [31:0] exp_d_rdata;
        logic [31:0] exp_i_rdata;
    } vec_t;

    vec_t vecs[5];

    // Request visible in cycle 0; samples taken 1 time unit after each edge.
    task automatic run_txn(input vec_t v, input string tag);
        int          en_cnt = 0, en_cyc = -1, done_cyc = -1, wrong_done = 0;
        logic        kind_ok = 1'b1, addr_ok = 1'b1, wdata_ok = 1'b1, own_ok = 1'b1, overlap = 1'b0;
        logic [31:0] got_d = 32'hx, got_i = 32'hx;
        logic [31:0] junk = 32'hBAD0BAD0;
        if (v.is_i) begin
            i_req = 1'b1; i_addr = v.a;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.a; d_wdata = v.wd;
        end
        miss = 1'b0; rdata = junk;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (read_enable && write_enable) overlap = 1'b1;
            if (read_enable || write_enable) begin
                en_cnt++; en_cyc = c;
                if (write_enable !== v.we) kind_ok = 1'b0;
                if (owner !== v.is_i) own_ok = 1'b0;
                if (v.we && wdata !== v.wd) wdata_ok = 1'b0;
            end
            if (busy && addr !== v.a) addr_ok = 1'b0;
            if ((v.is_i ? i_done : d_done) === 1'b1) begin
                done_cyc = c; got_d = d_rdata; got_i = i_rdata;
                d_req = 1'b0; i_req = 1'b0;
            end
            if ((v.is_i ? d_done : i_done) === 1'b1) wrong_done++;
            miss  = (c >= 2 && c < 2 + v.miss_n);
            rdata = (c >= 2 + v.miss_n) ? v.rd : junk;
        end
        d_req = 1'b0; i_req = 1'b0; miss = 1'b0;
        @(posedge clk); #1;
        check({tag, "_en_count"}, 32'(en_cnt), 32'd1);
        check({tag, "_en_cycle"}, 32'(en_cyc), 32'd1);
        check({tag, "_en_kind"}, {31'd0, kind_ok}, 32'd1);
        check({tag, "_owner"}, {31'd0, own_ok}, 32'd1);
        check({tag, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
        if (v.we) check({tag, "_wdata"}, {31'd0, wdata_ok}, 32'd1);
        check({tag, "_no_overlap"}, {31'd0, overlap}, 32'd0);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        check({tag, "_d_rdata"}, got_d, v.exp_d_rdata);
        check({tag, "_i_rdata"}, got_i, v.exp_i_rdata);
        check({tag, "_other_done"}, 32'(wrong_done), 32'd0);
    endtask

    initial begin
        int          re_cyc[2];
        logic [31:0] re_addr[2];
        logic        re_own[2];
        int          n_re, d_done_cyc, i_done_cyc, ng, bad_done;
        logic        seq[6];
        logic        exp_seq[6];
        vec_t        v;

        //          is_i  we    addr        wdata         rdata         miss done d_rdata       i_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hAAAA5555, 5, 8, 32'hAAAA5555, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h300, 32'h12345678, 32'h0BADF00D, 0, 3, 32'hAAAA5555, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h00000013, 2, 5, 32'hAAAA5555, 32'h00000013};
        vecs[4] = '{1'b1, 1'b0, 32'h44,  32'h0,        32'h00100093, 0, 3, 32'hAAAA5555, 32'h00100093};
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0; miss = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_enables", {30'd0, read_enable, write_enable}, 32'h0);
        check("rst_dones", {30'd0, d_done, i_done}, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_busy_owner", {30'd0, busy, owner}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

        // Both requesters rise together: data first, fetch granted in the d_done cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; i_req = 1'b1; i_addr = 32'h40;
        rdata = 32'h11112222; miss = 1'b0;
        n_re = 0; d_done_cyc = -1; i_done_cyc = -1;
        for (int c = 1; c <= 15 && i_done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (read_enable && n_re < 2) begin
                re_cyc[n_re] = c; re_addr[n_re] = addr; re_own[n_re] = owner; n_re++;
            end
            if (d_done) begin d_done_cyc = c; d_req = 1'b0; end
            if (i_done) begin i_done_cyc = c; i_req = 1'b0; end
        end
        d_req = 1'b0; i_req = 1'b0;
        check("both_re_count", 32'(n_re), 32'd2);
        if (n_re == 2) begin
            check("both_re0_cycle", 32'(re_cyc[0]), 32'd1);
            check("both_re0_addr", re_addr[0], 32'h200);
            check("both_re0_owner", {31'd0, re_own[0]}, 32'd0);
            check("both_re1_cycle", 32'(re_cyc[1]), 32'd4);
            check("both_re1_addr", re_addr[1], 32'h40);
            check("both_re1_owner", {31'd0, re_own[1]}, 32'd1);
        end
        check("both_d_done_cycle", 32'(d_done_cyc), 32'd3);
        check("both_i_done_cycle", 32'(i_done_cyc), 32'd6);
        repeat (2) @(posedge clk);
        #1;

        // Aging: fetch pulls its request in d_done cycles, data in i_done cycles,
        // so every grant is decided purely by the starve counter.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; i_req = 1'b1; i_addr = 32'h80;
        ng = 0;
        for (int c = 1; c <= 60 && ng < 6; c++) begin
            @(posedge clk); #1;
            if (read_enable) begin seq[ng] = owner; ng++; end
            d_req = ~i_done;
            i_req = ~d_done;
        end
        d_req = 1'b0; i_req = 1'b0;
        check("starve_grants", 32'(ng), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < ng) check($sformatf("starve_seq%0d", k), {31'd0, seq[k]}, {31'd0, exp_seq[k]});
        repeat (6) @(posedge clk);
        #1;

        // Reset in WAIT abandons the access.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; miss = 1'b0; rdata = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid_busy_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_enables", {30'd0, read_enable, write_enable}, 32'd0);
        check("rstmid_addr", addr, 32'h0);
        bad_done = {31'd0, d_done};
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (d_done || i_done) bad_done++;
        end
        check("rstmid_no_done", 32'(bad_done), 32'd0);
        v = '{1'b0, 1'b0, 32'h600, 32'h0, 32'hCAFEF00D, 0, 3, 32'hCAFEF00D, 32'h0};
        run_txn(v, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller sharing the single DRAM/cache port (addr, wdata, rdata, write_enable, read_enable, miss) between the CPU memory stage (data port) and a cache-backed instruction fetch path. It latches one request at a time, sequences the downstream access, waits out `miss`, and returns read data with a one-cycle done pulse to the owner. Arbitration is data-first with an aging counter so fetch cannot starve. It sits between the CPU core and the memory subsystem.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants made while `i_req` is pending before fetch is forced to win; 0 means pure data priority; range 0..255.
- Reset is synchronous and active-high; one clock.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `d_req`  in  1  data request, level; fields held stable until granted
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  write data
- `d_rdata`  out  32  registered read data
- `d_done`  out  1  one-cycle completion pulse
- `i_req`  in  1  fetch request, read only
- `i_addr`  in  32  fetch byte address
- `i_rdata`  out  32  registered instruction word
- `i_done`  out  1  one-cycle completion pulse
- `addr`  out  32  downstream address
- `wdata`  out  32  downstream write data
- `rdata`  in  32  downstream read data, valid in the completion cycle
- `write_enable`  out  1  downstream write strobe
- `read_enable`  out  1  downstream read strobe
- `miss`  in  1  downstream busy; 1 = access not complete
- `busy`  out  1  state != IDLE
- `owner`  out  1  0 = data, 1 = fetch; valid while busy

## Operation
- States are IDLE, ISSUE, and WAIT.
- IDLE:
  - Evaluates requests with the current done owner masked.
  - Picks fetch if `i_req` and (no `d_req`, or `STARVE_LIMIT` != 0 and `starve_cnt` == `STARVE_LIMIT`). Otherwise picks data if `d_req`.
  - On a grant, latches owner, addr, we, and wdata, then moves to ISSUE.
  - A fetch grant clears `starve_cnt`.
  - A data grant with `i_req` high increments `starve_cnt`, saturating at 255.
  - A data grant with `i_req` low clears `starve_cnt`.
- ISSUE:
  - Drives the latched addr/wdata and asserts exactly one of `read_enable` or `write_enable` for this single cycle.
  - Always moves to WAIT.
- WAIT:
  - Holds addr/wdata and keeps both enables low.
  - Stays while `miss` = 1.
  - On the first cycle with `miss` = 0, the access is complete: for a read, registers `rdata` into the owner's rdata register; registers the owner's done; moves to IDLE.
- Write completion pulses `d_done` and leaves `d_rdata` unchanged.
- Each rdata output holds its value until that owner's next read completes.
- Done masking: in the cycle `x_done` = 1, the same requester's `x_req` is ignored. The requester must drop or replace its request by the following cycle. The other requester may be granted in that cycle.
- Requester fields are sampled only at grant; later changes do not affect the access in flight.
- Reset:
  - Clears state to IDLE and `starve_cnt` to 0.
  - Outputs after reset: addr 0, wdata 0, both enables 0, both done 0, both rdata 0, busy 0, owner 0.
  - Reset during ISSUE or WAIT abandons the access with no done pulse. The downstream block shares `rst`.

## Timing
- Request seen in IDLE at cycle 0:
  - Enable asserted at cycle 1.
  - WAIT begins at cycle 2.
  - With `miss` low at cycle 2, done and rdata are visible at cycle 3.
- Minimum latency is 3 cycles. Each extra cycle of `miss` = 1 in WAIT adds one cycle.
- A back-to-back grant can occur in the done cycle (cycle 3), so throughput is 1 access per 3 cycles at zero wait.
- `miss` is ignored in IDLE and ISSUE.
- Both enables are never high together, and are never high outside ISSUE.

## Structure
- Put `arb_state_t` {IDLE, ISSUE, WAIT} and `arb_owner_t` {OWN_D, OWN_I} in the shared def package.
- One natural sub-module, `mem_arb_pick`, is purely combinational:
  - Inputs: masked requests, `starve_cnt`, `STARVE_LIMIT`.
  - Outputs: grant valid and grant owner.
- Everything else (FSM, latches, counter, output registers) lives in `mem_port_arbiter`.

## Test plan
- Data read, 0x100, `rdata` = 0xDEADBEEF, `miss` low: `read_enable` = 1 with addr 0x100 at cycle 1 only; `d_done` = 1 and `d_rdata` = 0xDEADBEEF at cycle 3; `i_done` stays 0.
- `d_req` and `i_req` rise together (0x200 / 0x40): data served first (`read_enable` cycle 1, `d_done` cycle 3); fetch granted at cycle 3, `read_enable` addr 0x40 at cycle 4, `i_done` at cycle 6.
- `miss` held 1 for 5 WAIT cycles: `d_done` at cycle 8; addr stable throughout; enables low after cycle 1.
- `STARVE_LIMIT` = 2, `d_req` and `i_req` held high continuously: grant sequence D,D,I,D,D,I.
- Data write, addr 0x300, wdata 0x12345678, prior `d_rdata` 0xAAAA5555: one `write_enable` cycle with those values; `d_done` at cycle 3; `d_rdata` remains 0xAAAA5555.
- `rst` asserted at cycle 2 (WAIT): at cycle 3 busy = 0, enables 0, addr 0, no done pulse ever; a new `d_req` afterwards completes normally in 3 cycles.
